alu_seq: RTL and testbench

//  Parametrised, registered successor to the combinational ALU: the same opcode set, plus
//  ADC, SHL, SHR and an iterative MUL, at width DW.
//  It exposes a valid/ready handshake so the datapath controller can stall on multi-cycle ops.
//  It sits between the register file read ports and the writeback mux.

---
 rtl/alu_seq_pkg.sv | 42 ++++
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_mul_serial.sv | 54 +++++
 rtl/alu_seq.sv | 141 ++++++++++++++
 tb/tb_alu_seq.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcode encoding, FSM states, flag positions.
package alu_seq_pkg;

  localparam int unsigned OpW = 4;

  typedef enum logic [OpW-1:0] {
    kMOV = 4'd0,
    kLFS = 4'd1,
    kADD = 4'd2,
    kSUB = 4'd3,
    kCMP = 4'd4,
    kXOR = 4'd5,
    kPAR = 4'd6,
    kADC = 4'd7,
    kSHL = 4'd8,
    kSHR = 4'd9,
    kMUL = 4'd10
  } op_mne;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StHold = 2'd2
  } alu_state_t;

  localparam int unsigned FZ = 0;
  localparam int unsigned FN = 1;
  localparam int unsigned FC = 2;
  localparam int unsigned FV = 3;

  function automatic logic [3:0] pack_flags(input logic v, input logic c, input logic n,
                                            input logic z);
    logic [3:0] f;
    f     = '0;
    f[FV] = v;
    f[FC] = c;
    f[FN] = n;
    f[FZ] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the register-file side and the writeback side.
interface alu_seq_if #(
  parameter int unsigned DW = 8
) ();
  import alu_seq_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  a;
  logic [DW-1:0]  b;
  logic [OpW-1:0] op;
  logic           sc_in;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  res;
  logic [3:0]     flag;

  modport master (
    output in_valid, a, b, op, sc_in, out_ready,
    input  in_ready, out_valid, res, flag
  );

  modport slave (
    input  in_valid, a, b, op, sc_in, out_ready,
    output in_ready, out_valid, res, flag
  );

endinterface

// File: rtl/alu_mul_serial.sv
// Unsigned shift-add multiplier, one partial-product step per cycle, DW steps per op.
module alu_mul_serial #(
  parameter int unsigned DW = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [DW-1:0]   a_i,
  input  logic [DW-1:0]   b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [2*DW-1:0] prod_o
);

  localparam int unsigned CntW = $clog2(DW) + 1;

  logic            busy_q;
  logic [CntW-1:0] cnt_q;
  logic [2*DW-1:0] acc_q, acc_d;
  logic [2*DW-1:0] mcand_q;
  logic [DW-1:0]   mplier_q;

  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // prod_o is the post-step value so the caller can capture it on the final step edge
  assign busy_o = busy_q;
  assign done_o = busy_q & (cnt_q == CntW'(DW - 1));
  assign prod_o = acc_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= {{DW{1'b0}}, a_i};
      mplier_q <= b_i;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake; MUL runs iteratively, everything else in one cycle.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  alu_seq_if.slave   bus_io
);

  alu_state_t      state_q;
  logic [DW-1:0]   res_q;
  logic [3:0]      flag_q;
  logic            out_valid_q;
  logic            en_q;

  op_mne           op;
  logic [DW-1:0]   a, b;
  logic            accept, drain, is_mul;
  logic [DW:0]     sum, diff;
  logic [DW-1:0]   alu_res;
  logic            alu_c, alu_v;
  logic [3:0]      alu_flag, mul_flag;

  logic            mul_start, mul_busy, mul_done;
  logic [2*DW-1:0] mul_prod;

  assign op = op_mne'(bus_io.op);
  assign a  = bus_io.a;
  assign b  = bus_io.b;

  // A held result being taken this cycle frees the slot, so HOLD can accept back-to-back
  assign bus_io.in_ready  = en_q & ~mul_busy & (state_q != StMul) &
                            (~out_valid_q | bus_io.out_ready);
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.res       = res_q;
  assign bus_io.flag      = flag_q;

  assign accept    = bus_io.in_valid & bus_io.in_ready;
  assign drain     = out_valid_q & bus_io.out_ready;
  assign is_mul    = (op == kMUL) && MUL_EN;
  assign mul_start = accept & is_mul;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    sum     = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, (op == kADC) & bus_io.sc_in};
    diff    = {1'b0, a} - {1'b0, b};
    case (op)
      kMOV: alu_res = b;
      kLFS: alu_res = {1'b0, a[DW-3:0], ^(a & b)};
      kADD, kADC: begin
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
        alu_v   = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
      end
      kSUB, kCMP: begin
        alu_res = diff[DW-1:0];
        alu_c   = ~diff[DW];
        alu_v   = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
      end
      kXOR: alu_res = a ^ b;
      kPAR: alu_res = {^a, a[DW-2:0]};
      kSHL: begin
        alu_res = {a[DW-2:0], bus_io.sc_in};
        alu_c   = a[DW-1];
      end
      kSHR: begin
        alu_res = {bus_io.sc_in, a[DW-1:1]};
        alu_c   = a[0];
      end
      default: alu_res = '0;
    endcase
  end

  assign alu_flag = pack_flags(alu_v, alu_c, alu_res[DW-1], alu_res == '0);
  assign mul_flag = pack_flags(1'b0, |mul_prod[2*DW-1:DW], mul_prod[DW-1],
                               mul_prod[DW-1:0] == '0);

  if (MUL_EN) begin : g_mul
    alu_mul_serial #(
      .DW(DW)
    ) u_mul (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .start_i(mul_start),
      .a_i    (a),
      .b_i    (b),
      .busy_o (mul_busy),
      .done_o (mul_done),
      .prod_o (mul_prod)
    );
  end else begin : g_no_mul
    logic unused_start;
    assign unused_start = mul_start;
    assign mul_busy     = 1'b0;
    assign mul_done     = 1'b0;
    assign mul_prod     = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      res_q       <= '0;
      flag_q      <= 4'b0001;
      out_valid_q <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      en_q <= 1'b1;
      case (state_q)
        StIdle, StHold: begin
          if (accept && is_mul) begin
            state_q     <= StMul;
            out_valid_q <= 1'b0;
          end else if (accept) begin
            state_q     <= StHold;
            out_valid_q <= 1'b1;
            res_q       <= alu_res;
            flag_q      <= alu_flag;
          end else if (drain) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
          end
        end
        StMul: begin
          if (mul_done) begin
            state_q     <= StHold;
            out_valid_q <= 1'b1;
            res_q       <= mul_prod[DW-1:0];
            flag_q      <= mul_flag;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq: DW=8 with MUL, DW=16 without MUL.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   busy_rdy;

  always #5 clk = ~clk;

  alu_seq_if #(.DW(8))  bus8  ();
  alu_seq_if #(.DW(16)) bus16 ();

  alu_seq #(.DW(8), .MUL_EN(1'b1)) u_dut8 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus8)
  );

  alu_seq #(.DW(16), .MUL_EN(1'b0)) u_dut16 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus16)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input bit w16);
    return w16 ? bus16.in_ready : bus8.in_ready;
  endfunction

  function automatic logic vld(input bit w16);
    return w16 ? bus16.out_valid : bus8.out_valid;
  endfunction

  task automatic run_op(input bit w16, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic sc, output logic [15:0] res,
                        output logic [3:0] flg, output int lat);
    int k;
    @(negedge clk);
    if (w16) begin
      bus16.op = op; bus16.a = a; bus16.b = b; bus16.sc_in = sc; bus16.in_valid = 1'b1;
    end else begin
      bus8.op = op; bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.sc_in = sc; bus8.in_valid = 1'b1;
    end
    #1;
    k = 0;
    while (!rdy(w16) && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 50) check_eq("in_ready_timeout", 32'(k), 32'd0);
    @(posedge clk); #1;
    bus8.in_valid  = 1'b0;
    bus16.in_valid = 1'b0;
    lat = 1;
    while (!vld(w16) && lat < 40) begin
      if (rdy(w16)) busy_rdy++;
      @(posedge clk); #1;
      lat++;
    end
    res = w16 ? bus16.res : {8'h00, bus8.res};
    flg = w16 ? bus16.flag : bus8.flag;
  endtask

  typedef struct {
    string      tag;
    bit         w16;
    logic [3:0] op;
    logic [15:0] a;
    logic [15:0] b;
    logic       sc;
    logic [15:0] res;
    logic [3:0] flg;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [15:0] r;
    logic [3:0]  f;
    int          lat;
    int          bad;

    bus8.in_valid = 0;  bus8.out_ready = 1;  bus8.a = 0;  bus8.b = 0;  bus8.op = 0;
    bus8.sc_in = 0;
    bus16.in_valid = 0; bus16.out_ready = 1; bus16.a = 0; bus16.b = 0; bus16.op = 0;
    bus16.sc_in = 0;

    // Reset state while held low
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_out", 32'(bus8.res), 32'h0);
    check_eq("rst_flag", 32'(bus8.flag), 32'h1);
    check_eq("rst_valid", 32'(bus8.out_valid), 32'h0);
    check_eq("rst_ready", 32'(bus8.in_ready), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready_held", 32'(bus8.in_ready), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rel_ready8", 32'(bus8.in_ready), 32'h1);
    check_eq("rel_ready16", 32'(bus16.in_ready), 32'h1);

    // {V,C,N,Z} flag order
    vecs.push_back('{"add_ovf",   0, kADD, 16'h7F, 16'h01, 0, 16'h80, 4'b1010, 1});
    vecs.push_back('{"adc_wrap",  0, kADC, 16'hFF, 16'h00, 1, 16'h00, 4'b0101, 1});
    vecs.push_back('{"sub_eq",    0, kSUB, 16'h05, 16'h05, 0, 16'h00, 4'b0101, 1});
    vecs.push_back('{"cmp_eq",    0, kCMP, 16'h05, 16'h05, 0, 16'h00, 4'b0101, 1});
    vecs.push_back('{"sub_neg",   0, kSUB, 16'h03, 16'h05, 0, 16'hFE, 4'b0010, 1});
    vecs.push_back('{"cmp_neg",   0, kCMP, 16'h03, 16'h05, 0, 16'hFE, 4'b0010, 1});
    vecs.push_back('{"sub_ovf",   0, kSUB, 16'h80, 16'h01, 0, 16'h7F, 4'b1100, 1});
    vecs.push_back('{"xor",       0, kXOR, 16'hA5, 16'h0F, 0, 16'hAA, 4'b0010, 1});
    vecs.push_back('{"mov_zero",  0, kMOV, 16'h55, 16'h00, 0, 16'h00, 4'b0001, 1});
    vecs.push_back('{"lfs",       0, kLFS, 16'hFF, 16'h01, 0, 16'h7F, 4'b0000, 1});
    vecs.push_back('{"shl",       0, kSHL, 16'h81, 16'h00, 0, 16'h02, 4'b0100, 1});
    vecs.push_back('{"par8",      0, kPAR, 16'h03, 16'h00, 0, 16'h03, 4'b0000, 1});
    vecs.push_back('{"undef",     0, 4'hF, 16'h12, 16'h34, 1, 16'h00, 4'b0001, 1});
    vecs.push_back('{"mul_ovf",   0, kMUL, 16'h10, 16'h10, 0, 16'h00, 4'b0101, 9});
    vecs.push_back('{"mul_143",   0, kMUL, 16'h0D, 16'h0B, 0, 16'h8F, 4'b0010, 9});
    vecs.push_back('{"mul_ff",    0, kMUL, 16'hFF, 16'hFF, 0, 16'h01, 4'b0100, 9});
    vecs.push_back('{"par16",     1, kPAR, 16'h8001, 16'h0, 0, 16'h0001, 4'b0000, 1});
    vecs.push_back('{"shr16",     1, kSHR, 16'h0001, 16'h0, 1, 16'h8000, 4'b0110, 1});
    vecs.push_back('{"mul_nop16", 1, kMUL, 16'h1234, 16'h5, 0, 16'h0000, 4'b0001, 1});
    vecs.push_back('{"add16",     1, kADD, 16'hFFFF, 16'h1, 0, 16'h0000, 4'b0101, 1});
    vecs.push_back('{"lfs16",     1, kLFS, 16'hFFFF, 16'h3, 0, 16'h7FFE, 4'b0000, 1});

    foreach (vecs[i]) begin
      busy_rdy = 0;
      run_op(vecs[i].w16, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sc, r, f, lat);
      check_eq({vecs[i].tag, "_out"}, 32'(r), 32'(vecs[i].res));
      check_eq({vecs[i].tag, "_flag"}, 32'(f), 32'(vecs[i].flg));
      check_eq({vecs[i].tag, "_lat"}, 32'(lat), 32'(vecs[i].lat));
      if (vecs[i].lat > 1) check_eq({vecs[i].tag, "_busy_rdy"}, 32'(busy_rdy), 32'd0);
    end

    // Backpressure: result must hold while the consumer stalls
    bus8.out_ready = 1'b0;
    run_op(0, kADD, 16'h12, 16'h34, 0, r, f, lat);
    check_eq("bp_out", 32'(r), 32'h46);
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus8.res !== 8'h46 || bus8.flag !== 4'b0000 || bus8.in_ready !== 1'b0 ||
          bus8.out_valid !== 1'b1) bad++;
    end
    check_eq("bp_stable", 32'(bad), 32'd0);

    // Drain and accept in the same cycle, then back-to-back singles
    bus8.op = kXOR; bus8.a = 8'h0F; bus8.b = 8'hF0; bus8.sc_in = 0; bus8.in_valid = 1'b1;
    bus8.out_ready = 1'b1;
    #1;
    check_eq("bp_drain_rdy", 32'(bus8.in_ready), 32'h1);
    @(posedge clk); #1;
    check_eq("b2b_xor_out", 32'(bus8.res), 32'hFF);
    check_eq("b2b_xor_flag", 32'(bus8.flag), 32'b0010);
    bus8.op = kADD; bus8.a = 8'h01; bus8.b = 8'h01;
    @(posedge clk); #1;
    check_eq("b2b_add1", 32'(bus8.res), 32'h02);
    check_eq("b2b_add1_vld", 32'(bus8.out_valid), 32'h1);
    bus8.a = 8'h02; bus8.b = 8'h02;
    @(posedge clk); #1;
    check_eq("b2b_add2", 32'(bus8.res), 32'h04);
    bus8.a = 8'h40; bus8.b = 8'h40;
    @(posedge clk); #1;
    check_eq("b2b_add3", 32'(bus8.res), 32'h80);
    check_eq("b2b_add3_flag", 32'(bus8.flag), 32'b1010);
    bus8.in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("b2b_drained", 32'(bus8.out_valid), 32'h0);

    // Reset in the middle of a MUL aborts it
    @(negedge clk);
    bus8.op = kMUL; bus8.a = 8'h03; bus8.b = 8'h05; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(bus8.out_valid), 32'h0);
    check_eq("midrst_out", 32'(bus8.res), 32'h0);
    check_eq("midrst_flag", 32'(bus8.flag), 32'h1);
    check_eq("midrst_ready", 32'(bus8.in_ready), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_rel_ready", 32'(bus8.in_ready), 32'h1);
    bad = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus8.out_valid !== 1'b0) bad++;
    end
    check_eq("midrst_no_result", 32'(bad), 32'd0);
    run_op(0, kADD, 16'h02, 16'h03, 0, r, f, lat);
    check_eq("post_rst_add", 32'(r), 32'h05);
    check_eq("post_rst_lat", 32'(lat), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
